// File: rtl/taxi_disp_pkg.sv
// Shared constants for the taxi meter display scanner.
package taxi_disp_pkg;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Code the segment decoder renders as an unlit digit.
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  // Default number of scanned digits.
  localparam int N_DIGITS_DEF = 8;

endpackage

// File: rtl/disp_prescale.sv
// Digit-slot prescaler: counts SCAN_DIV clocks per slot and flags the last
// cycle of each slot so the scanner can advance to the next digit.
module disp_prescale #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign cnt      = cnt_q;

  // Next count: wrap to zero at the end of each slot.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (slot_end) begin
      cnt_d = '0;
    end
  end

  // Slot counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed BCD display scanner for the taxi meter readout.
// Snapshots the digit and decimal-point inputs once per frame, then lights
// one digit per slot with a short all-off period at the start of each slot
// to suppress ghosting. All outputs are registered (1-cycle latency).
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank zero digits above the
// most-significant nonzero digit (digit 0 always shown).
module disp_scan
  import taxi_disp_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGIT_W*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]         dp_mask,
  output logic [DIGIT_W-1:0]          q,
  output logic [N_DIGITS-1:0]         an,
  output logic                        dp,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             frame_wrap;
  logic             lit;

  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_DIGITS-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [N_DIGITS-1:0]             shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]             lz_blank;

  logic [N_DIGITS-1:0] an_q, an_d;
  logic [DIGIT_W-1:0]  q_q, q_d;
  logic                dp_q, dp_d;
  logic                frame_done_q, frame_done_d;

  disp_prescale #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_prescale (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  // Last cycle of the last digit's slot: the only point inputs are sampled.
  assign frame_wrap = slot_end && (idx_q == IDX_LAST);

  // Anti-ghost window: digits stay dark for the first BLANK_CYC cycles of a slot.
  assign lit = (int'(cnt) >= BLANK_CYC);

  // Digit index advance and once-per-frame snapshot of the inputs.
  always_comb begin
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_wrap) begin
      shadow_d    = digits;
      shadow_dp_d = dp_mask;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Find the most-significant nonzero digit; everything above it is a leading zero.
  always_comb begin
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (shadow_q[i] != '0) begin
        msd = IDX_W'(i);
      end
    end
    lz_blank = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      lz_blank[i] = (IDX_W'(i) > msd);
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output decode from the current slot position and the frame snapshot.
  always_comb begin
    an_d         = '1;
    q_d          = BLANK_CODE;
    dp_d         = 1'b1;
    frame_done_d = frame_wrap;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      q_d         = lz_blank[idx_q] ? BLANK_CODE : shadow_q[idx_q];
      dp_d        = ~shadow_dp_q[idx_q];
    end
  end

  // Scan state, snapshot and output registers; reset forces all digits off.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      an_q         <= '1;
      q_q          <= BLANK_CODE;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      q_q          <= q_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign q          = q_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan.sv
// Testbench for disp_scan (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1).
module tb_disp_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  q;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  disp_scan #(
    .N_DIGITS  (ND),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .q          (q),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: k = clock edges since reset; the slot position
  // and digit follow from plain division, the snapshot reloads every frame.
  logic [15:0] sh;
  logic [3:0]  shdp;
  int          k;
  int          mc, md;
  bit          mdl_on = 1'b0;
  logic [3:0]  e_an, e_q;
  logic        e_dp, e_fd;

  function automatic logic [3:0] shown(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int msd = 0;
    for (int i = 0; i < ND; i++) if (sh[i*4 +: 4] != 4'h0) msd = i;
    if (d > msd) return 4'hF;
`endif
    return sh[d*4 +: 4];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_on = 1'b1;
      k = 0; sh = '0; shdp = '0;
      e_an = 4'hF; e_q = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
    end else if (mdl_on) begin
      mc = k % SD;
      md = (k / SD) % ND;
      if (mc >= BC) begin
        e_an = ~(4'b0001 << md);
        e_q  = shown(md);
        e_dp = ~shdp[md];
      end else begin
        e_an = 4'hF; e_q = 4'hF; e_dp = 1'b1;
      end
      e_fd = ((k % (SD*ND)) == SD*ND - 1);
      if (e_fd) begin
        sh = digits;
        shdp = dp_mask;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("mdl_an", an, e_an);
      chk("mdl_q", q, e_q);
      chk("mdl_dp", dp, e_dp);
      chk("mdl_frame_done", frame_done, e_fd);
    end
  end

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    chk(tag, frame_done, 1'b1);
  endtask

  logic [3:0] ord_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] ord_q  [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] lz_q   [4] = '{4'h0, 4'h5, 4'hF, 4'hF};
`else
  logic [3:0] lz_q   [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
`endif

  initial begin
    int slot, c, n;
    rst = 1'b1; digits = 16'h1234; dp_mask = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_q", q, 4'hF);
      chk("rst_dp", dp, 1'b1);
      chk("rst_fd", frame_done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_blank_an", an, 4'hF);
    @(negedge clk);
    chk("first_lit_an", an, 4'b1110);
    chk("first_lit_q", q, 4'h0);

    // Digit order after the first snapshot; change inputs mid-frame.
    wait_fd("fd_first");
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      slot = j / 4; c = j % 4;
      chk("order_an", an, (c == 0) ? 4'hF : ord_an[slot]);
      chk("order_q", q, (c == 0) ? 4'hF : ord_q[slot]);
      chk("order_fd", frame_done, (j == 15));
      if (j == 5) digits = 16'h9999;
    end
    @(negedge clk);
    @(negedge clk);
    chk("snap_an", an, 4'b1110);
    chk("snap_q", q, 4'h9);

    // Mid-scan reset while digit 2 is lit.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== 4'b1011 && n < 40);
    chk("reach_digit2", an, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", an, 4'hF);
    chk("midrst_q", q, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_blank_an", an, 4'hF);
    @(negedge clk);
    chk("restart_an", an, 4'b1110);
    chk("restart_q", q, 4'h0);

    // Leading-zero handling and decimal point on digit 2.
    digits = 16'h0050; dp_mask = 4'b0100;
    wait_fd("fd_blank");
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      slot = j / 4; c = j % 4;
      chk("blank_q", q, (c == 0) ? 4'hF : lz_q[slot]);
      chk("dp_bit", dp, (c != 0 && slot == 2) ? 1'b0 : 1'b1);
    end
    digits = 16'h0000;
    wait_fd("fd_zero");
    @(negedge clk);
    @(negedge clk);
    chk("zero_an", an, 4'b1110);
    chk("zero_q", q, 4'h0);

    // Randomized inputs and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
